spi_ctrl_regbank: RTL and testbench
===================================

Name: spi_ctrl_regbank

Overview:
- Parametrised successor to the sensor's SPI command decoder and control register bank.
- Takes byte-framed SPI traffic (an 8-bit parallel byte with a strobe, already deserialised upstream) on a single clock.
- Holds NUM_REGS control registers of REG_W bits.
- Expands the group-control registers into per-channel reset, read and enable vectors for NUM_CH double-column channels.
- Adds timed auto-clearing reset pulses, a status register, error flagging and frame abort, none of which the previous decoder had.

Parameters:
- NUM_REGS, 4, number of control registers; legal range 4..15; index 15 is reserved for status.
- REG_W, 4, register width in bits; legal range 1..8.
- NUM_CH, 32, channel count; must be a multiple of REG_W; G = NUM_CH/REG_W channels per group bit.
- PULSE_LEN, 4, length of the RESET command pulse in clk1 cycles; legal range 1..255.
- SYNC_BYTE, 8'h00, frame start byte.

Ports:
- clk1, input, 1, sole clock.
- sys_reset_n, input, 1, synchronous active-low reset.
- ss, input, 1, slave select, active high; low aborts the current frame.
- mosi, input, 8, received byte.
- mosi_vld, input, 1, one-cycle strobe qualifying mosi.
- miso, output, 8, read-back byte.
- miso_vld, output, 1, one-cycle strobe qualifying miso.
- cfg_regs, output, NUM_REGS*REG_W, flattened registers; reg k occupies [k*REG_W +: REG_W].
- chan_rst, output, NUM_CH, expansion of reg1.
- chan_read, output, NUM_CH, expansion of reg2.
- chan_en, output, NUM_CH, expansion of reg3.
- start_pulse, output, 1, one-cycle pulse on START.
- busy, output, 1, high while a RESET pulse is active.
- cmd_err, output, 1, sticky error flag.

Behaviour:
- Reset (sys_reset_n low at a clk1 edge): all registers 0; miso=0; miso_vld=0; start_pulse=0; busy=0; cmd_err=0; FSM=IDLE; pulse counter=0.
- A byte is accepted only when mosi_vld && ss. ss low in any state returns the FSM to IDLE next cycle with no register change; a pending write is discarded. An active PULSE still completes.
- FSM states: IDLE, GTCD, WDAT, PULSE.
  - IDLE: accepted byte == SYNC_BYTE -> GTCD. Any other byte is ignored.
  - GTCD: accepted byte latched as cmd. Fields: op = cmd[7:6], idx = cmd[5:2], cmd[1:0] reserved and ignored. Action depends on op:
    - op 00 (WR): -> WDAT.
    - op 01 (RD): next cycle miso = zero-extended reg[idx] and miso_vld = 1 for one cycle. If idx == 15, miso = {cmd_err, busy, 6'b0} and cmd_err is cleared in the same cycle. If NUM_REGS <= idx < 15, miso = 8'hFF and cmd_err is set. -> IDLE.
    - op 10 (RESET): reg0[2:1] = 2'b11 and reg1 = all ones next cycle; busy = 1; counter = PULSE_LEN; -> PULSE.
    - op 11 (START): next cycle reg0[0] = 1, reg2 = all ones, reg3 = all ones, start_pulse = 1 for one cycle; -> IDLE.
  - WDAT: accepted byte -> reg[idx] = byte[REG_W-1:0] on the next edge; upper byte bits are ignored. idx >= NUM_REGS (including 15): no write, cmd_err set. -> IDLE.
  - PULSE: counter decrements every cycle. When the counter reaches 1, the next edge clears reg0[2:1] and reg1 to 0, sets busy = 0, and returns to IDLE. busy is therefore high for exactly PULSE_LEN cycles. Any byte accepted during PULSE is dropped and sets cmd_err.
- Channel expansion: register bit b drives channels NUM_CH-1-b*G down to NUM_CH-(b+1)*G. Example (defaults): reg3[0] drives chan_en[31:24]; reg3[3] drives chan_en[7:0]. The expansion is purely combinational from the registers.
- Latency:
  - Register write is visible on cfg_regs and the expanded vectors 1 cycle after the accepted data byte.
  - Read data is presented 1 cycle after the accepted command byte.
- Simultaneous events:
  - sys_reset_n has priority over everything.
  - When a cmd_err set and the status-read clear occur in the same cycle, set wins.
- Registers other than those a command touches hold their value. START does not auto-clear; software clears the bits with WR.

Test Plan:
- Defaults; bytes 00, 0x0C (WR idx3), 0x05 -> reg3 = 4'h5 one cycle after the data byte. chan_en[31:24] = all ones, [23:16] = 0, [15:8] = all ones, [7:0] = 0.
- Bytes 00, 0x44 (RD idx1) after reg1 = 4'hA -> one cycle later miso = 8'h0A, miso_vld high for exactly 1 cycle.
- PULSE_LEN = 4; bytes 00, 0x80 -> reg0[2:1] = 11 and chan_rst = all ones with busy = 1 for exactly 4 cycles, then all 0. A byte strobed during the pulse sets cmd_err.
- Bytes 00, 0x20 (WR idx8), 0x03 -> no register change, cmd_err = 1. Then 00, 0x7C (RD idx15) -> miso = 8'h80, and cmd_err = 0 afterwards.
- Bytes 00, 0x00 (WR idx0), ss dropped before the data byte -> reg0 unchanged, FSM in IDLE. A subsequent full frame writes normally.
- START (00, 0xC0) -> start_pulse high for 1 cycle; reg0[0] = 1, chan_read and chan_en all ones. Then sys_reset_n low for 1 edge -> all outputs 0.

Source files
------------

// File: rtl/spi_ctrl_regbank_if.sv
// spi_ctrl_regbank_if: byte-framed SPI link between the deserialiser and the register bank
interface spi_ctrl_regbank_if;
    logic       ss;
    logic [7:0] mosi;
    logic       mosi_vld;
    logic [7:0] miso;
    logic       miso_vld;
    modport master (output ss, mosi, mosi_vld, input miso, miso_vld);
    modport slave (input ss, mosi, mosi_vld, output miso, miso_vld);
endinterface

// File: rtl/spi_ctrl_regbank.sv
// spi_ctrl_regbank: SPI command decoder, control register bank and per-channel vector expansion
module spi_ctrl_regbank #(
    parameter int         NUM_REGS  = 4,
    parameter int         REG_W     = 4,
    parameter int         NUM_CH    = 32,
    parameter int         PULSE_LEN = 4,
    parameter logic [7:0] SYNC_BYTE = 8'h00
) (
    input  logic                      clk1,
    input  logic                      sys_reset_n,
    spi_ctrl_regbank_if.slave         bus,
    output logic [NUM_REGS*REG_W-1:0] cfg_regs,
    output logic [NUM_CH-1:0]         chan_rst,
    output logic [NUM_CH-1:0]         chan_read,
    output logic [NUM_CH-1:0]         chan_en,
    output logic                      start_pulse,
    output logic                      busy,
    output logic                      cmd_err
);
    localparam int G = NUM_CH / REG_W;
    localparam logic [4:0] NR = 5'(NUM_REGS);
    // reg0 bit roles: [0] start, [2:1] reset; narrow registers simply lose the missing bits
    localparam logic [REG_W-1:0] RST_M = REG_W'(3'b110);
    localparam logic [REG_W-1:0] START_M = REG_W'(1'b1);

    typedef enum logic [1:0] {IDLE, GTCD, WDAT, PULSE} state_t;

    state_t           state;
    logic [3:0]       idx;
    logic [7:0]       cnt;
    logic [REG_W-1:0] r [NUM_REGS];
    logic [7:0]       rd8;
    logic             acc;
    logic             cmd_ok;
    logic             idx_ok;

    assign acc = bus.mosi_vld && bus.ss;
    assign cmd_ok = {1'b0, bus.mosi[5:2]} < NR;
    assign idx_ok = {1'b0, idx} < NR;

    always_comb begin
        rd8 = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (bus.mosi[5:2] == 4'(k)) rd8[REG_W-1:0] = r[k];
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign cfg_regs[k*REG_W +: REG_W] = r[k];
    end

    // bit 0 of a group register feeds the top group of channels
    for (genvar b = 0; b < REG_W; b++) begin : g_exp
        assign chan_rst[NUM_CH-1-b*G -: G]  = {G{r[1][b]}};
        assign chan_read[NUM_CH-1-b*G -: G] = {G{r[2][b]}};
        assign chan_en[NUM_CH-1-b*G -: G]   = {G{r[3][b]}};
    end

    always_ff @(posedge clk1) begin
        if (!sys_reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            bus.miso    <= '0;
            bus.miso_vld <= 1'b0;
            start_pulse <= 1'b0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) r[k] <= '0;
        end else begin
            bus.miso_vld <= 1'b0;
            start_pulse  <= 1'b0;
            case (state)
                IDLE: if (acc && bus.mosi == SYNC_BYTE) state <= GTCD;
                GTCD: begin
                    if (!bus.ss) state <= IDLE;
                    else if (acc) begin
                        idx <= bus.mosi[5:2];
                        case (bus.mosi[7:6])
                            2'b00: state <= WDAT;
                            2'b01: begin
                                bus.miso_vld <= 1'b1;
                                state        <= IDLE;
                                if (bus.mosi[5:2] == 4'hF) begin
                                    bus.miso <= {cmd_err, busy, 6'b0};
                                    cmd_err  <= 1'b0;
                                end else if (!cmd_ok) begin
                                    bus.miso <= 8'hFF;
                                    cmd_err  <= 1'b1;
                                end else bus.miso <= rd8;
                            end
                            2'b10: begin
                                r[0]  <= r[0] | RST_M;
                                r[1]  <= '1;
                                busy  <= 1'b1;
                                cnt   <= 8'(PULSE_LEN);
                                state <= PULSE;
                            end
                            default: begin
                                r[0]        <= r[0] | START_M;
                                r[2]        <= '1;
                                r[3]        <= '1;
                                start_pulse <= 1'b1;
                                state       <= IDLE;
                            end
                        endcase
                    end
                end
                WDAT: begin
                    if (!bus.ss) state <= IDLE;
                    else if (acc) begin
                        if (idx_ok) begin
                            for (int k = 0; k < NUM_REGS; k++)
                                if (idx == 4'(k)) r[k] <= bus.mosi[REG_W-1:0];
                        end else cmd_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                PULSE: begin
                    if (acc) cmd_err <= 1'b1;
                    if (cnt == 8'd1) begin
                        r[0]  <= r[0] & ~RST_M;
                        r[1]  <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else cnt <= cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ctrl_regbank.sv
// tb_spi_ctrl_regbank: directed and randomized frames checked against a register-level model
module tb_spi_ctrl_regbank;
    logic        clk1 = 1'b0;
    logic        sys_reset_n = 1'b0;
    logic [15:0] cfg_regs;
    logic [31:0] chan_rst, chan_read, chan_en;
    logic        start_pulse, busy, cmd_err;
    int          passed = 0;
    int          total = 0;
    logic [3:0]  m [4];
    logic        m_err;

    spi_ctrl_regbank_if bus();

    spi_ctrl_regbank dut (
        .clk1(clk1), .sys_reset_n(sys_reset_n), .bus(bus),
        .cfg_regs(cfg_regs), .chan_rst(chan_rst), .chan_read(chan_read), .chan_en(chan_en),
        .start_pulse(start_pulse), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2_000_000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] expand(logic [3:0] v);
        logic [31:0] e;
        for (int c = 0; c < 32; c++) e[c] = v[(31 - c) / 8];
        return e;
    endfunction

    task automatic check_all(string tag, logic exp_busy);
        chk({tag, ".cfg"}, 64'(cfg_regs), 64'({m[3], m[2], m[1], m[0]}));
        chk({tag, ".rst"}, 64'(chan_rst), 64'(expand(m[1])));
        chk({tag, ".read"}, 64'(chan_read), 64'(expand(m[2])));
        chk({tag, ".en"}, 64'(chan_en), 64'(expand(m[3])));
        chk({tag, ".err"}, 64'(cmd_err), 64'(m_err));
        chk({tag, ".busy"}, 64'(busy), 64'(exp_busy));
    endtask

    task automatic put(logic [7:0] b);
        bus.mosi = b;
        bus.mosi_vld = 1'b1;
        @(negedge clk1);
        bus.mosi_vld = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk1);
    endtask

    task automatic wr(logic [3:0] idx, logic [7:0] d);
        put(8'h00); gap();
        put({2'b00, idx, 2'($urandom)}); gap();
        put(d);
        if (idx < 4) m[idx[1:0]] = d[3:0];
        else m_err = 1'b1;
        check_all("wr", 1'b0);
        gap();
    endtask

    task automatic rd(logic [3:0] idx);
        logic [7:0] e;
        put(8'h00); gap();
        put({2'b01, idx, 2'($urandom)});
        if (idx == 4'hF) begin
            e = {m_err, 7'b0};
            m_err = 1'b0;
        end else if (idx < 4) e = {4'b0, m[idx[1:0]]};
        else begin
            e = 8'hFF;
            m_err = 1'b1;
        end
        chk("rd.vld", 64'(bus.miso_vld), 64'(1));
        chk("rd.data", 64'(bus.miso), 64'(e));
        check_all("rd", 1'b0);
        @(negedge clk1);
        chk("rd.vld_off", 64'(bus.miso_vld), 64'(0));
        gap();
    endtask

    task automatic pulse(bit stray);
        int n = 0;
        put(8'h00); gap();
        put({2'b10, 6'($urandom)});
        m[0] = m[0] | 4'b0110;
        m[1] = 4'hF;
        check_all("pulse.on", 1'b1);
        if (stray) begin
            bus.mosi = 8'($urandom);
            bus.mosi_vld = 1'b1;
        end
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk1);
            bus.mosi_vld = 1'b0;
        end
        chk("pulse.len", 64'(n), 64'(4));
        m[0] = m[0] & 4'b1001;
        m[1] = 4'h0;
        if (stray) m_err = 1'b1;
        check_all("pulse.off", 1'b0);
        gap();
    endtask

    task automatic start();
        put(8'h00); gap();
        put({2'b11, 6'($urandom)});
        m[0] = m[0] | 4'b0001;
        m[2] = 4'hF;
        m[3] = 4'hF;
        chk("start.on", 64'(start_pulse), 64'(1));
        check_all("start", 1'b0);
        @(negedge clk1);
        chk("start.off", 64'(start_pulse), 64'(0));
        gap();
    endtask

    task automatic abort_frame(bit with_cmd, bit with_data);
        put(8'h00); gap();
        if (with_cmd) put({2'b00, 4'($urandom), 2'b00});
        bus.ss = 1'b0;
        @(negedge clk1);
        bus.ss = 1'b1;
        if (with_data) put(8'($urandom_range(1, 255)));
        check_all("abort", 1'b0);
        gap();
    endtask

    task automatic check_reset(string tag);
        for (int k = 0; k < 4; k++) m[k] = 4'h0;
        m_err = 1'b0;
        check_all(tag, 1'b0);
        chk({tag, ".miso"}, 64'(bus.miso), 64'(0));
        chk({tag, ".miso_vld"}, 64'(bus.miso_vld), 64'(0));
        chk({tag, ".start"}, 64'(start_pulse), 64'(0));
    endtask

    initial begin
        bus.ss = 1'b1;
        bus.mosi = 8'h00;
        bus.mosi_vld = 1'b0;
        repeat (3) @(negedge clk1);
        check_reset("reset");
        sys_reset_n = 1'b1;
        @(negedge clk1);
        wr(4'd3, 8'h05);
        chk("en.pattern", 64'(chan_en), 64'(32'hFF00_FF00));
        wr(4'd1, 8'hFA);
        rd(4'd1);
        pulse(1'b1);
        wr(4'd8, 8'h03);
        rd(4'hF);
        abort_frame(1'b1, 1'b1);
        wr(4'd0, 8'h09);
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0, 1: wr(4'($urandom), 8'($urandom));
                2: rd(4'($urandom));
                3: pulse(1'($urandom));
                4: start();
                5: abort_frame(1'($urandom), 1'($urandom));
                default: begin
                    put(8'($urandom_range(1, 255)));
                    check_all("junk", 1'b0);
                end
            endcase
        end
        start();
        sys_reset_n = 1'b0;
        @(negedge clk1);
        sys_reset_n = 1'b1;
        check_reset("final_reset");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
